ball_track_ctrl: RTL and testbench

- Frame-level sequencer for the green-ball detection datapath.
- Gates the detector's enable strictly on frame boundaries.
- Qualifies the per-frame hotbox result (grid x/y plus green count) against a confidence threshold, and tracks position and per-frame velocity.
- Declares the ball lost after consecutive misses; downstream paddle/game logic consumes POS/VEL/TRACK_VALID.

---
 rtl/ball_track_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_ball_track_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ball_track_ctrl.sv
// ============================================================================
// Module   : ball_track_ctrl
// Purpose  : Frame-level sequencer and tracker for the green-ball detector.
//            Optional prediction output enabled by BALL_TRACK_PREDICT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ball_track_ctrl #(
  parameter int COLS          = 40,
  parameter int ROWS          = 30,
  parameter int MIN_COUNT     = 8,
  parameter int SETTLE_FRAMES = 2,
  parameter int LOST_FRAMES   = 4
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        START,
  input  logic        STOP,
  input  logic        VGA_VS,
  input  logic        BALL_VALID,
  input  logic [5:0]  BALL_X,
  input  logic [4:0]  BALL_Y,
  input  logic [7:0]  BALL_COUNT,
  output logic        DET_ENABLE,
  output logic        TRACK_VALID,
  output logic        LOST,
  output logic [5:0]  POS_X,
  output logic [4:0]  POS_Y,
  output logic [6:0]  VEL_X,
  output logic [5:0]  VEL_Y,
  output logic [5:0]  PRED_X,
  output logic [4:0]  PRED_Y,
  output logic [15:0] FRAME_CNT,
  output logic [2:0]  STATE
);

  localparam int c_settle_w = $clog2(SETTLE_FRAMES + 1);
  localparam int c_miss_w   = $clog2(LOST_FRAMES + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_SEARCH = 3'd2,
    ST_TRACK  = 3'd3,
    ST_LOST   = 3'd4
  } state_t;

  state_t                r_state;
  logic                  r_vs_d;
  logic                  r_det_enable;
  logic                  r_track_valid;
  logic                  r_lost;
  logic [5:0]            r_pos_x;
  logic [4:0]            r_pos_y;
  logic [6:0]            r_vel_x;
  logic [5:0]            r_vel_y;
  logic [15:0]           r_frame_cnt;
  logic [c_settle_w-1:0] r_settle_cnt;
  logic [c_miss_w-1:0]   r_miss_cnt;
  logic                  r_got_valid;

  logic                  w_fs;
  logic                  w_accept;
  logic                  w_run_state;

  assign w_fs        = r_vs_d & ~VGA_VS;
  assign w_accept    = BALL_VALID && (BALL_COUNT >= 8'(MIN_COUNT)) &&
                       (BALL_X < 6'(COLS)) && (BALL_Y < 5'(ROWS));
  assign w_run_state = (r_state == ST_SETTLE) || (r_state == ST_SEARCH) ||
                       (r_state == ST_TRACK);

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state       <= ST_IDLE;
      r_vs_d        <= 1'b1;
      r_det_enable  <= 1'b0;
      r_track_valid <= 1'b0;
      r_lost        <= 1'b0;
      r_pos_x       <= '0;
      r_pos_y       <= '0;
      r_vel_x       <= '0;
      r_vel_y       <= '0;
      r_frame_cnt   <= '0;
      r_settle_cnt  <= '0;
      r_miss_cnt    <= '0;
      r_got_valid   <= 1'b0;
    end else begin
      r_vs_d <= VGA_VS;
      r_lost <= 1'b0;

      // Enable only moves on a frame boundary so the detector never sees a partial frame
      if (w_fs) begin
        r_det_enable <= w_run_state;
        if (r_state != ST_IDLE) begin
          r_frame_cnt <= r_frame_cnt + 16'd1;
        end
      end

      if ((r_state != ST_IDLE) && STOP) begin
        r_state       <= ST_IDLE;
        r_track_valid <= 1'b0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (START && !STOP) begin
              r_state      <= ST_SETTLE;
              r_settle_cnt <= '0;
              r_frame_cnt  <= '0;
              r_miss_cnt   <= '0;
              r_got_valid  <= 1'b0;
            end
          end

          ST_SETTLE: begin
            if (w_fs) begin
              r_settle_cnt <= r_settle_cnt + 1'b1;
              if (r_settle_cnt + 1'b1 == c_settle_w'(SETTLE_FRAMES)) begin
                r_state <= ST_SEARCH;
              end
            end
          end

          ST_SEARCH: begin
            if (w_accept) begin
              r_pos_x       <= BALL_X;
              r_pos_y       <= BALL_Y;
              r_vel_x       <= '0;
              r_vel_y       <= '0;
              r_track_valid <= 1'b1;
              r_miss_cnt    <= '0;
              r_got_valid   <= 1'b0;
              r_state       <= ST_TRACK;
            end
          end

          ST_TRACK: begin
            if (w_accept) begin
              r_vel_x     <= {1'b0, BALL_X} - {1'b0, r_pos_x};
              r_vel_y     <= {1'b0, BALL_Y} - {1'b0, r_pos_y};
              r_pos_x     <= BALL_X;
              r_pos_y     <= BALL_Y;
              r_got_valid <= 1'b1;
              r_miss_cnt  <= '0;
            end
            // A result arriving on the fs cycle still belongs to the closing frame
            if (w_fs) begin
              if (!(r_got_valid || w_accept)) begin
                r_miss_cnt <= r_miss_cnt + 1'b1;
                if (r_miss_cnt + 1'b1 == c_miss_w'(LOST_FRAMES)) begin
                  r_state       <= ST_LOST;
                  r_lost        <= 1'b1;
                  r_track_valid <= 1'b0;
                  r_vel_x       <= '0;
                  r_vel_y       <= '0;
                end
              end else begin
                r_got_valid <= 1'b0;
              end
            end
          end

          ST_LOST: begin
            r_state    <= ST_SEARCH;
            r_miss_cnt <= '0;
          end

          default: begin
            r_state <= ST_IDLE;
          end
        endcase
      end
    end
  end

`ifdef BALL_TRACK_PREDICT_EN
  logic signed [7:0] w_sum_x;
  logic signed [6:0] w_sum_y;
  logic [5:0]        w_clamp_x;
  logic [4:0]        w_clamp_y;
  logic [5:0]        r_pred_x;
  logic [4:0]        r_pred_y;

  assign w_sum_x = $signed({2'b00, r_pos_x}) + $signed({r_vel_x[6], r_vel_x});
  assign w_sum_y = $signed({2'b00, r_pos_y}) + $signed({r_vel_y[5], r_vel_y});

  always_comb begin
    w_clamp_x = w_sum_x[5:0];
    w_clamp_y = w_sum_y[4:0];
    if (w_sum_x[7]) begin
      w_clamp_x = '0;
    end else if (w_sum_x[6:0] > 7'(COLS - 1)) begin
      w_clamp_x = 6'(COLS - 1);
    end
    if (w_sum_y[6]) begin
      w_clamp_y = '0;
    end else if (w_sum_y[5:0] > 6'(ROWS - 1)) begin
      w_clamp_y = 5'(ROWS - 1);
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_pred_x <= '0;
      r_pred_y <= '0;
    end else begin
      r_pred_x <= r_track_valid ? w_clamp_x : 6'd0;
      r_pred_y <= r_track_valid ? w_clamp_y : 5'd0;
    end
  end

  assign PRED_X = r_pred_x;
  assign PRED_Y = r_pred_y;
`else
  assign PRED_X = r_pos_x;
  assign PRED_Y = r_pos_y;
`endif

  assign DET_ENABLE  = r_det_enable;
  assign TRACK_VALID = r_track_valid;
  assign LOST        = r_lost;
  assign POS_X       = r_pos_x;
  assign POS_Y       = r_pos_y;
  assign VEL_X       = r_vel_x;
  assign VEL_Y       = r_vel_y;
  assign FRAME_CNT   = r_frame_cnt;
  assign STATE       = r_state;

endmodule

`default_nettype wire

// File: tb/tb_ball_track_ctrl.sv
// ============================================================================
// Module   : tb_ball_track_ctrl
// Purpose  : Directed scoreboard bench for ball_track_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ball_track_ctrl;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        START;
  logic        STOP;
  logic        VGA_VS;
  logic        BALL_VALID;
  logic [5:0]  BALL_X;
  logic [4:0]  BALL_Y;
  logic [7:0]  BALL_COUNT;
  logic        DET_ENABLE;
  logic        TRACK_VALID;
  logic        LOST;
  logic [5:0]  POS_X;
  logic [4:0]  POS_Y;
  logic [6:0]  VEL_X;
  logic [5:0]  VEL_Y;
  logic [5:0]  PRED_X;
  logic [4:0]  PRED_Y;
  logic [15:0] FRAME_CNT;
  logic [2:0]  STATE;

  ball_track_ctrl dut (
    .CLK(CLK), .RST_N(RST_N), .START(START), .STOP(STOP), .VGA_VS(VGA_VS),
    .BALL_VALID(BALL_VALID), .BALL_X(BALL_X), .BALL_Y(BALL_Y),
    .BALL_COUNT(BALL_COUNT), .DET_ENABLE(DET_ENABLE),
    .TRACK_VALID(TRACK_VALID), .LOST(LOST), .POS_X(POS_X), .POS_Y(POS_Y),
    .VEL_X(VEL_X), .VEL_Y(VEL_Y), .PRED_X(PRED_X), .PRED_Y(PRED_Y),
    .FRAME_CNT(FRAME_CNT), .STATE(STATE)
  );

  always #5 CLK = ~CLK;

  localparam int S_STATE = 0, S_DET = 1, S_TV = 2, S_LOST = 3, S_PX = 4,
                 S_PY = 5, S_VX = 6, S_VY = 7, S_FC = 8, S_PRX = 9, S_PRY = 10;

  typedef struct {
    int    cyc;
    int    sel;
    int    exp;
    string name;
  } exp_t;

  exp_t q[$];
  int   lost_q[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  function automatic int actual(input int sel);
    case (sel)
      S_STATE: return int'(STATE);
      S_DET:   return int'(DET_ENABLE);
      S_TV:    return int'(TRACK_VALID);
      S_LOST:  return int'(LOST);
      S_PX:    return int'(POS_X);
      S_PY:    return int'(POS_Y);
      S_VX:    return int'($signed(VEL_X));
      S_VY:    return int'($signed(VEL_Y));
      S_FC:    return int'(FRAME_CNT);
      S_PRX:   return int'(PRED_X);
      S_PRY:   return int'(PRED_Y);
      default: return -999;
    endcase
  endfunction

  // Monitor: pops expectations due this cycle and checks every LOST pulse
  always @(negedge CLK) begin
    exp_t e;
    int   act;
    int   ec;
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      e   = q.pop_front();
      act = actual(e.sel);
      checks++;
      if (e.cyc != cyc || act != e.exp) begin
        failures++;
        $display("FAIL %s: got %0d expected %0d (cycle %0d)", e.name, act, e.exp, cyc);
      end
    end
    if (LOST) begin
      checks++;
      if (lost_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_lost: got LOST=1 expected 0 (cycle %0d)", cyc);
      end else begin
        ec = lost_q.pop_front();
        if (ec != cyc) begin
          failures++;
          $display("FAIL lost_timing: got cycle %0d expected %0d", cyc, ec);
        end
      end
    end
  end

  task automatic chk(input int sel, input int exp, input string name);
    exp_t e;
    e.cyc = cyc; e.sel = sel; e.exp = exp; e.name = name;
    q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic fs_cycle();
    tick(2);
    VGA_VS = 1'b0;
    tick();
    VGA_VS = 1'b1;
  endtask

  task automatic ball(input int x, input int y, input int c);
    BALL_VALID = 1'b1; BALL_X = 6'(x); BALL_Y = 5'(y); BALL_COUNT = 8'(c);
    tick();
    BALL_VALID = 1'b0;
  endtask

  task automatic ball_fs(input int x, input int y, input int c);
    tick(2);
    VGA_VS = 1'b0;
    BALL_VALID = 1'b1; BALL_X = 6'(x); BALL_Y = 5'(y); BALL_COUNT = 8'(c);
    tick();
    BALL_VALID = 1'b0;
    VGA_VS = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0; START = 1'b0; STOP = 1'b0; VGA_VS = 1'b1;
    BALL_VALID = 1'b0; BALL_X = '0; BALL_Y = '0; BALL_COUNT = '0;
    tick(3);
    RST_N = 1'b1;
    tick();
    chk(S_STATE, 0, "rst_state"); chk(S_DET, 0, "rst_det");
    chk(S_TV, 0, "rst_tv"); chk(S_FC, 0, "rst_fc"); chk(S_PX, 0, "rst_posx");

    // START and STOP together in IDLE
    START = 1'b1; STOP = 1'b1; tick(); START = 1'b0; STOP = 1'b0;
    chk(S_STATE, 0, "startstop_idle");

    // Arm
    START = 1'b1; tick(); START = 1'b0;
    chk(S_STATE, 1, "arm_settle"); chk(S_DET, 0, "arm_det_not_at_start");
    tick(2);
    chk(S_DET, 0, "arm_det_before_fs");
    fs_cycle();
    chk(S_STATE, 1, "settle_fs1"); chk(S_DET, 1, "det_first_fs"); chk(S_FC, 1, "fc_1");
    fs_cycle();
    chk(S_STATE, 2, "search_fs2"); chk(S_FC, 2, "fc_2"); chk(S_DET, 1, "det_search");

    // Acquire
    tick(2);
    ball(10, 5, 7);
    chk(S_STATE, 2, "reject_low_count"); chk(S_TV, 0, "reject_tv");
    ball(40, 5, 100);
    chk(S_STATE, 2, "reject_x_range");
    ball(10, 30, 100);
    chk(S_STATE, 2, "reject_y_range");
    ball(10, 5, 8);
    chk(S_STATE, 3, "acq_state"); chk(S_PX, 10, "acq_px"); chk(S_PY, 5, "acq_py");
    chk(S_VX, 0, "acq_vx"); chk(S_VY, 0, "acq_vy"); chk(S_TV, 1, "acq_tv");

    // Velocity
    tick(2);
    ball(13, 3, 20);
    chk(S_VX, 3, "vel1_x"); chk(S_VY, -2, "vel1_y"); chk(S_PX, 13, "vel1_px");
    tick();
`ifdef BALL_TRACK_PREDICT_EN
    chk(S_PRX, 16, "pred1_x"); chk(S_PRY, 1, "pred1_y");
`else
    chk(S_PRX, 13, "pred1_x"); chk(S_PRY, 3, "pred1_y");
`endif
    ball(0, 29, 20);
    chk(S_VX, -13, "vel2_x"); chk(S_VY, 26, "vel2_y");
    tick();
    chk(S_PRX, 0, "pred2_x"); chk(S_PRY, 29, "pred2_y");

    // Three misses then a coincident hit
    fs_cycle();
    fs_cycle(); fs_cycle(); fs_cycle();
    chk(S_STATE, 3, "miss3_state"); chk(S_TV, 1, "miss3_tv");
    ball_fs(1, 1, 20);
    chk(S_STATE, 3, "coinc_state"); chk(S_PX, 1, "coinc_px");
    chk(S_VX, 1, "coinc_vx"); chk(S_VY, -28, "coinc_vy"); chk(S_FC, 7, "coinc_fc");

    // Three misses then a plain hit resets the count
    fs_cycle(); fs_cycle(); fs_cycle();
    tick(2);
    ball(2, 2, 20);
    chk(S_VX, 1, "hit_vx"); chk(S_VY, 1, "hit_vy");
    fs_cycle();
    fs_cycle(); fs_cycle(); fs_cycle();
    chk(S_STATE, 3, "pre_lost_state"); chk(S_TV, 1, "pre_lost_tv");

    // Fourth consecutive miss
    fs_cycle();
    lost_q.push_back(cyc);
    chk(S_STATE, 4, "lost_state"); chk(S_LOST, 1, "lost_pulse");
    chk(S_TV, 0, "lost_tv"); chk(S_VX, 0, "lost_vx"); chk(S_PX, 2, "lost_px_held");
    chk(S_FC, 15, "lost_fc");
    tick();
    chk(S_STATE, 2, "after_lost_search"); chk(S_LOST, 0, "lost_one_cycle");

    // Reacquire then STOP mid-frame
    ball(20, 10, 50);
    chk(S_STATE, 3, "reacq_state");
    tick(2);
    STOP = 1'b1; tick(); STOP = 1'b0;
    chk(S_STATE, 0, "stop_idle"); chk(S_TV, 0, "stop_tv");
    chk(S_DET, 1, "stop_det_held"); chk(S_PX, 20, "stop_px_held");
    tick();
`ifdef BALL_TRACK_PREDICT_EN
    chk(S_PRX, 0, "stop_pred_x");
`else
    chk(S_PRX, 20, "stop_pred_x");
`endif
    tick(2);
    chk(S_DET, 1, "stop_det_until_fs");
    fs_cycle();
    chk(S_DET, 0, "stop_det_drop"); chk(S_FC, 15, "stop_fc_frozen");

    // Reset mid-frame
    START = 1'b1; tick(); START = 1'b0;
    fs_cycle();
    chk(S_DET, 1, "rearm_det");
    tick(2);
    VGA_VS = 1'b0;
    RST_N = 1'b0; tick();
    chk(S_STATE, 0, "midrst_state"); chk(S_DET, 0, "midrst_det");
    chk(S_FC, 0, "midrst_fc"); chk(S_PX, 0, "midrst_px");
    RST_N = 1'b1; VGA_VS = 1'b1;
    tick(3);

    checks++;
    if (lost_q.size() != 0) begin
      failures++;
      $display("FAIL lost_missing: got %0d pending expected 0", lost_q.size());
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL unchecked: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
